// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, CTRL/STATUS bit
// positions and the TARGET reset value.
package timer_pkg;

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_TARGET = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_OS    = 2;
  localparam int CTRL_IE    = 3;
  localparam int CTRL_CASC  = 4;
  localparam int CTRL_PRESC = 8;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;

  localparam logic [31:0] TARGET_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, COUNT/TARGET/CTRL/STATUS, match and W1C logic.
// MULTI_TIMER_CASCADE_EN enables CTRL[4] so channel IDX>0 ticks on casc_in.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDE = 32,
  parameter int IDX  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] din,
  input  logic        casc_in,
  output logic [31:0] rdata,
  output logic        match_p,
  output logic        flag,
  output logic        irq_req
);

  logic [WIDE-1:0] count_q, count_d, target_q, target_d;
  logic            en_q, en_d, ar_q, ar_d, os_q, os_d, ie_q, ie_d, casc_q, casc_d;
  logic [7:0]      presc_q, presc_d, psc_q, psc_d;
  logic [1:0]      status_q, status_d;
  logic            wr_count, wr_target, wr_ctrl, wr_status;
  logic            stop_wr, own_tick, tick, hit, hold, wrap;
  logic [31:0]     ctrl_rd;
  logic            unused_din;

  assign wr_count  = wr_en && (reg_sel == REG_COUNT);
  assign wr_target = wr_en && (reg_sel == REG_TARGET);
  assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
  assign wr_status = wr_en && (reg_sel == REG_STATUS);
  assign unused_din = ^din;

  // A CTRL write clearing en suppresses a tick landing on that same edge.
  assign stop_wr  = wr_ctrl && !din[CTRL_EN];
  assign own_tick = en_q && (psc_q == presc_q);
  assign tick     = en_q && !stop_wr && ((casc_q && (IDX > 0)) ? casc_in : own_tick);
  assign hit      = (count_q == target_q);
  assign match_p  = tick && hit;
  assign hold     = hit && !ar_q && os_q;
  assign wrap     = tick && (&count_q) && !(hit && (ar_q || os_q));

  always_comb begin
    psc_d = psc_q + 8'd1;
    if (!en_q || stop_wr || own_tick) psc_d = 8'd0;

    count_d = count_q;
    if (tick) begin
      if (hit && ar_q) count_d = '0;
      else if (!hold)  count_d = count_q + 1'b1;
    end
    if (wr_count) count_d = din[WIDE-1:0];

    target_d = wr_target ? din[WIDE-1:0] : target_q;

    en_d    = en_q;
    ar_d    = ar_q;
    os_d    = os_q;
    ie_d    = ie_q;
    casc_d  = casc_q;
    presc_d = presc_q;
    if (match_p && hold) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d    = din[CTRL_EN];
      ar_d    = din[CTRL_AR];
      os_d    = din[CTRL_OS];
      ie_d    = din[CTRL_IE];
      presc_d = din[CTRL_PRESC +: 8];
`ifdef MULTI_TIMER_CASCADE_EN
      casc_d  = din[CTRL_CASC];
`else
      casc_d  = 1'b0;
`endif
    end

    // Hardware set wins over a simultaneous W1C.
    status_d = (status_q & ~(wr_status ? din[1:0] : 2'b00)) | {wrap, match_p};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      target_q <= TARGET_RST[WIDE-1:0];
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      os_q     <= 1'b0;
      ie_q     <= 1'b0;
      casc_q   <= 1'b0;
      presc_q  <= 8'd0;
      psc_q    <= 8'd0;
      status_q <= 2'b00;
    end else begin
      count_q  <= count_d;
      target_q <= target_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      os_q     <= os_d;
      ie_q     <= ie_d;
      casc_q   <= casc_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    ctrl_rd                     = '0;
    ctrl_rd[CTRL_EN]            = en_q;
    ctrl_rd[CTRL_AR]            = ar_q;
    ctrl_rd[CTRL_OS]            = os_q;
    ctrl_rd[CTRL_IE]            = ie_q;
    ctrl_rd[CTRL_CASC]          = casc_q;
    ctrl_rd[CTRL_PRESC +: 8]    = presc_q;
    case (reg_sel)
      REG_COUNT:  rdata = 32'(count_q);
      REG_TARGET: rdata = 32'(target_q);
      REG_CTRL:   rdata = ctrl_rd;
      default:    rdata = 32'(status_q);
    endcase
  end

  assign flag    = status_q[ST_MATCH];
  assign irq_req = status_q[ST_MATCH] && ie_q;

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer: address decode, read mux and irq OR.
// Define MULTI_TIMER_CASCADE_EN to let channel i>0 tick on channel i-1 matches.
module multi_timer
  import timer_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int WIDE = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [4:0]     addr,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  output logic [NCH-1:0] flag,
  output logic           irq
);

  logic [2:0]     ch_sel;
  logic [31:0]    rd [NCH];
  logic [NCH-1:0] match_p, casc_in, irq_req;
  logic           unused_match;

  assign ch_sel       = addr[4:2];
  assign unused_match = match_p[NCH-1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_i;
    assign wr_i = we && (ch_sel == 3'(i));
    if (i == 0) begin : g_first
      assign casc_in[i] = 1'b0;
    end else begin : g_chain
      assign casc_in[i] = match_p[i-1];
    end
    timer_channel #(.WIDE(WIDE), .IDX(i)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_i),
      .reg_sel (addr[1:0]),
      .din     (din),
      .casc_in (casc_in[i]),
      .rdata   (rd[i]),
      .match_p (match_p[i]),
      .flag    (flag[i]),
      .irq_req (irq_req[i])
    );
  end

  // Unpopulated channel slots read as zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 3'(i)) dout = rd[i];
    end
  end

  assign irq = |irq_req;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register-map table plus timed sequences.
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  addr;
  logic [31:0] din, dout;
  logic [3:0]  flag;
  logic        irq;
  int          n_chk = 0;
  int          n_err = 0;

`ifdef MULTI_TIMER_CASCADE_EN
  localparam logic [31:0] CH2_CTRL_EXP = 32'h0000_FF1E;
`else
  localparam logic [31:0] CH2_CTRL_EXP = 32'h0000_FF0E;
`endif

  typedef struct {
    bit          is_wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  multi_timer #(.NCH(4), .WIDE(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .flag (flag),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a; #1;
    chk(name, dout, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; addr = '0; din = '0;
    tbl.push_back('{1'b0, 5'h00, 32'h0,         32'h0,         "rst_count0"});
    tbl.push_back('{1'b0, 5'h01, 32'h0,         32'hFFFF_FFFF, "rst_target0"});
    tbl.push_back('{1'b0, 5'h02, 32'h0,         32'h0,         "rst_ctrl0"});
    tbl.push_back('{1'b0, 5'h03, 32'h0,         32'h0,         "rst_status0"});
    tbl.push_back('{1'b0, 5'h0D, 32'h0,         32'hFFFF_FFFF, "rst_target3"});
    tbl.push_back('{1'b0, 5'h15, 32'h0,         32'h0,         "rd_ch5_target"});
    tbl.push_back('{1'b1, 5'h15, 32'h1234,      32'h0,         ""});
    tbl.push_back('{1'b0, 5'h15, 32'h0,         32'h0,         "wr_ch5_ignored"});
    tbl.push_back('{1'b0, 5'h05, 32'h0,         32'hFFFF_FFFF, "ch5_no_alias"});
    tbl.push_back('{1'b1, 5'h0A, 32'hFFF0_FF1E, 32'h0,         ""});
    tbl.push_back('{1'b0, 5'h0A, 32'h0,         CH2_CTRL_EXP,  "ctrl_readback"});
    tbl.push_back('{1'b1, 5'h0A, 32'h0,         32'h0,         ""});
    tbl.push_back('{1'b1, 5'h08, 32'h0000_ABCD, 32'h0,         ""});
    tbl.push_back('{1'b0, 5'h08, 32'h0,         32'h0000_ABCD, "count_wr"});
    tbl.push_back('{1'b1, 5'h09, 32'h55,        32'h0,         ""});
    tbl.push_back('{1'b0, 5'h09, 32'h0,         32'h55,        "target_wr"});
    tbl.push_back('{1'b1, 5'h0B, 32'hFFFF_FFFF, 32'h0,         ""});
    tbl.push_back('{1'b0, 5'h0B, 32'h0,         32'h0,         "status_ro"});

    #1; chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_flag", {28'b0, flag}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].d);
      else rd(tbl[i].name, tbl[i].a, tbl[i].exp);
    end

    // ch0 auto-reload, TARGET=5, presc=0
    wr(5'h01, 32'd5);
    wr(5'h02, 32'h0B);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ar_flag_c%0d", k), {31'b0, flag[0]}, 32'(k == 6));
    end
    chk("ar_irq", {31'b0, irq}, 32'h1);
    rd("ar_count_reload", 5'h00, 32'h0);
    wr(5'h03, 32'h1);
    chk("w1c_quiet_flag", {31'b0, flag[0]}, 32'h0);
    chk("w1c_quiet_irq", {31'b0, irq}, 32'h0);
    for (int k = 8; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ar_repeat_c%0d", k), {31'b0, flag[0]}, 32'(k == 12));
    end
    repeat (5) @(posedge clk);
    #1;
    wr(5'h03, 32'h1);
    chk("w1c_vs_set_flag", {31'b0, flag[0]}, 32'h1);
    rd("w1c_vs_set_status", 5'h03, 32'h1);
    wr(5'h02, 32'h0);
    wr(5'h03, 32'h1);
    chk("disabled_irq", {31'b0, irq}, 32'h0);
    cyc(3);
    rd("freeze_count", 5'h00, 32'h0);

    // ch1 one-shot, TARGET=3, presc=1
    wr(5'h05, 32'd3);
    wr(5'h06, 32'h105);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("os_flag_c%0d", k), {31'b0, flag[1]}, 32'(k == 8));
    end
    chk("os_irq_masked", {31'b0, irq}, 32'h0);
    rd("os_en_cleared", 5'h06, 32'h104);
    rd("os_count", 5'h04, 32'h3);
    cyc(4);
    rd("os_count_held", 5'h04, 32'h3);
    wr(5'h07, 32'h1);

    // ch2 wrap through all-ones with TARGET=0
    wr(5'h09, 32'h0);
    wr(5'h08, 32'hFFFF_FFFE);
    wr(5'h0A, 32'h1);
    cyc(2);
    rd("wrap_count", 5'h08, 32'h0);
    rd("wrap_status", 5'h0B, 32'h2);
    chk("wrap_no_match", {31'b0, flag[2]}, 32'h0);
    cyc(1);
    chk("wrap_then_match", {31'b0, flag[2]}, 32'h1);
    rd("wrap_status2", 5'h0B, 32'h3);
    rd("wrap_count2", 5'h08, 32'h1);
    wr(5'h0A, 32'h0);
    wr(5'h0B, 32'h3);
    rd("wrap_status_clr", 5'h0B, 32'h0);

    // ch3 bus write to COUNT on the matching tick
    wr(5'h0D, 32'd2);
    wr(5'h0E, 32'h1);
    cyc(2);
    wr(5'h0C, 32'h40);
    rd("wr_wins_count", 5'h0C, 32'h40);
    chk("wr_wins_match", {31'b0, flag[3]}, 32'h1);
    wr(5'h0E, 32'h0);

    // asynchronous reset mid-count, then first tick after presc+1 cycles
    wr(5'h02, 32'h1);
    cyc(3);
    rd("pre_rst_count", 5'h00, 32'h3);
    #2 rst = 1'b0;
    #1;
    rd("async_count", 5'h00, 32'h0);
    rd("async_target", 5'h05, 32'hFFFF_FFFF);
    chk("async_flag", {28'b0, flag}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wr(5'h02, 32'h201);
    cyc(2);
    rd("presc2_before", 5'h00, 32'h0);
    cyc(1);
    rd("presc2_tick", 5'h00, 32'h1);
    wr(5'h02, 32'h0);

`ifdef MULTI_TIMER_CASCADE_EN
    wr(5'h00, 32'h0);
    wr(5'h06, 32'h11);
    wr(5'h01, 32'd1);
    wr(5'h02, 32'h3);
    cyc(8);
    rd("casc_ch1_count", 5'h04, 32'h4);
    rd("casc_ch0_count", 5'h00, 32'h0);
`else
    wr(5'h06, 32'h10);
    rd("casc_bit_ro", 5'h06, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
